// File: rtl/unified_sync_mem.sv
// rtl/unified_sync_mem.sv - single-clock memory with fetch, load and store ports
// A post-reset sequencer zeroes the array; ready gates all requests until it finishes.
module unified_sync_mem #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 12,
  parameter int DEPTH      = 1 << AWIDTH,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              if_en,
  input  logic [AWIDTH-1:0] if_addr,
  output logic [DWIDTH-1:0] if_dout,
  output logic              if_valid,
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_addr,
  output logic [DWIDTH-1:0] ld_dout,
  output logic              ld_valid,
  input  logic              st_en,
  input  logic [AWIDTH-1:0] st_addr,
  input  logic [DWIDTH-1:0] st_din
);

  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] clr_ptr;
  logic [DWIDTH-1:0] mem [0:DEPTH-1];

  logic              if_in, ld_in, st_in, st_go;
  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic [DWIDTH-1:0] wr_data;
  logic [DWIDTH-1:0] if_word, ld_word;

  // Range checks use one extra bit so DEPTH == 2^AWIDTH still compares correctly.
  assign if_in = {1'b0, if_addr} < DEPTH_W;
  assign ld_in = {1'b0, ld_addr} < DEPTH_W;
  assign st_in = {1'b0, st_addr} < DEPTH_W;
  assign st_go = (state == S_RUN) && st_en && st_in;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = st_addr[IW-1:0];
    wr_data = st_din;
    if (state == S_INIT) begin
      wr_en   = rst_n && INIT_CLEAR;
      wr_idx  = clr_ptr[IW-1:0];
      wr_data = '0;
    end else if (st_go) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Write-first: a same-edge store to the read address bypasses the array.
  always_comb begin
    if_word = '0;
    if (if_in) begin
      if (st_go && (st_addr == if_addr)) if_word = st_din;
      else                               if_word = mem[if_addr[IW-1:0]];
    end
  end

  always_comb begin
    ld_word = '0;
    if (ld_in) begin
      if (st_go && (st_addr == ld_addr)) ld_word = st_din;
      else                               ld_word = mem[ld_addr[IW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      clr_ptr  <= '0;
      ready    <= 1'b0;
      if_dout  <= '0;
      if_valid <= 1'b0;
      ld_dout  <= '0;
      ld_valid <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ld_valid <= 1'b0;
      case (state)
        S_INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (!INIT_CLEAR || (clr_ptr == LAST)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (if_en) begin
            if_valid <= 1'b1;
            if_dout  <= if_word;
          end
          if (ld_en) begin
            ld_valid <= 1'b1;
            ld_dout  <= ld_word;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_sync_mem.sv
// tb/tb_unified_sync_mem.sv - scoreboard bench for unified_sync_mem
module tb_unified_sync_mem;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int D  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ready;
  logic          if_en, ld_en, st_en, if_valid, ld_valid;
  logic [AW-1:0] if_addr, ld_addr, st_addr;
  logic [DW-1:0] st_din, if_dout, ld_dout;

  logic          rst2_n, ready2;
  logic          if2_en, ld2_en, st2_en, if2_valid, ld2_valid;
  logic [7:0]    if2_addr, ld2_addr, st2_addr;
  logic [DW-1:0] st2_din, if2_dout, ld2_dout;

  unified_sync_mem #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(D), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .if_en(if_en), .if_addr(if_addr), .if_dout(if_dout), .if_valid(if_valid),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_dout(ld_dout), .ld_valid(ld_valid),
    .st_en(st_en), .st_addr(st_addr), .st_din(st_din)
  );

  unified_sync_mem #(.DWIDTH(DW), .AWIDTH(8), .DEPTH(64), .INIT_CLEAR(1'b1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .ready(ready2),
    .if_en(if2_en), .if_addr(if2_addr), .if_dout(if2_dout), .if_valid(if2_valid),
    .ld_en(ld2_en), .ld_addr(ld2_addr), .ld_dout(ld2_dout), .ld_valid(ld2_valid),
    .st_en(st2_en), .st_addr(st2_addr), .st_din(st2_din)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model [D];
  logic          run;
  logic [DW-1:0] hold_if, hold_ld;
  logic          exp_ifv, exp_ldv;
  logic [DW-1:0] if_q [$];
  logic [DW-1:0] ld_q [$];
  logic [DW-1:0] ld2_q [$];
  logic [DW-1:0] e_if, e_ld, e2;

  function automatic logic [DW-1:0] model_read(int a, logic se, int sa, logic [DW-1:0] sd);
    if (a >= D) return '0;
    if (se && sa == a) return sd;
    return model[a];
  endfunction

  // Drives one cycle on dut, pushes the expected douts, and returns 1ns after the edge.
  task automatic step(input logic ie, input int ia, input logic le, input int la,
                      input logic se, input int sa, input logic [DW-1:0] sd);
    if_en = ie; if_addr = AW'(ia);
    ld_en = le; ld_addr = AW'(la);
    st_en = se; st_addr = AW'(sa); st_din = sd;
    exp_ifv = run && ie;
    exp_ldv = run && le;
    if (exp_ifv) hold_if = model_read(ia, se, sa, sd);
    if (exp_ldv) hold_ld = model_read(la, se, sa, sd);
    if_q.push_back(hold_if);
    ld_q.push_back(hold_ld);
    if (run && se && sa < D) model[sa] = sd;
    @(posedge clk);
    #1;
    if_en = 1'b0; ld_en = 1'b0; st_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst2_n = 1'b0; run = 1'b0;
    hold_if = '0; hold_ld = '0;
    if_en = 0; ld_en = 0; st_en = 0; if_addr = '0; ld_addr = '0; st_addr = '0; st_din = '0;
    if2_en = 0; ld2_en = 0; st2_en = 0; if2_addr = '0; ld2_addr = '0; st2_addr = '0; st2_din = '0;
    #12;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", ready); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    vectors++; if (ld_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ld_valid got=%b exp=0", ld_valid); end
    vectors++; if (if_dout !== '0) begin miscompares++; $display("FAIL reset_if_dout got=%h exp=0", if_dout); end
    vectors++; if (ld_dout !== '0) begin miscompares++; $display("FAIL reset_ld_dout got=%h exp=0", ld_dout); end
  endtask

  // Clear must take exactly D edges; fetch and store requests during it are ignored.
  task automatic test_clear_lockout;
    rst_n = 1'b1;
    for (int i = 1; i <= D; i++) begin
      step(1'b1, 5, 1'b0, 0, 1'b1, 5, 16'hBEEF);
      e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
      vectors++; if (ready !== (i == D)) begin miscompares++; $display("FAIL clear_ready cyc=%0d got=%b exp=%b", i, ready, (i == D)); end
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL init_if_valid cyc=%0d got=%b exp=0", i, if_valid); end
      vectors++; if (if_dout !== e_if) begin miscompares++; $display("FAIL init_if_hold cyc=%0d got=%h exp=%h", i, if_dout, e_if); end
    end
    for (int a = 0; a < D; a++) model[a] = '0;
    run = 1'b1;
  endtask

  task automatic test_clear_readback;
    for (int a = 0; a < D; a++) begin
      step(1'b0, 0, 1'b1, a, 1'b0, 0, '0);
      e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
      vectors++; if (ld_valid !== 1'b1) begin miscompares++; $display("FAIL clear_ld_valid a=%0d got=%b exp=1", a, ld_valid); end
      vectors++; if (ld_dout !== e_ld) begin miscompares++; $display("FAIL clear_ld_dout a=%0d got=%h exp=%h", a, ld_dout, e_ld); end
    end
  endtask

  task automatic test_fetch_load;
    step(1'b0, 0, 1'b0, 0, 1'b1, 3, 16'h1234);
    e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
    step(1'b1, 3, 1'b1, 3, 1'b0, 0, '0);
    e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL fl_if_valid got=%b exp=1", if_valid); end
    vectors++; if (ld_valid !== 1'b1) begin miscompares++; $display("FAIL fl_ld_valid got=%b exp=1", ld_valid); end
    vectors++; if (if_dout !== e_if) begin miscompares++; $display("FAIL fl_if_dout got=%h exp=%h", if_dout, e_if); end
    vectors++; if (ld_dout !== e_ld) begin miscompares++; $display("FAIL fl_ld_dout got=%h exp=%h", ld_dout, e_ld); end
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, '0);
    e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
    vectors++; if ({if_valid, ld_valid} !== 2'b00) begin miscompares++; $display("FAIL fl_valid_drop got=%b exp=00", {if_valid, ld_valid}); end
    vectors++; if (if_dout !== 16'h1234) begin miscompares++; $display("FAIL fl_if_hold got=%h exp=1234", if_dout); end
    vectors++; if (ld_dout !== 16'h1234) begin miscompares++; $display("FAIL fl_ld_hold got=%h exp=1234", ld_dout); end
  endtask

  task automatic test_write_first;
    step(1'b1, 10, 1'b1, 10, 1'b1, 10, 16'h00AA);
    e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
    vectors++; if (ld_dout !== 16'h00AA) begin miscompares++; $display("FAIL wf_ld_dout got=%h exp=00aa", ld_dout); end
    vectors++; if (if_dout !== 16'h00AA) begin miscompares++; $display("FAIL wf_if_dout got=%h exp=00aa", if_dout); end
    step(1'b0, 0, 1'b1, 10, 1'b1, 9, 16'h5555);
    e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
    vectors++; if (ld_dout !== e_ld) begin miscompares++; $display("FAIL wf_other_addr got=%h exp=%h", ld_dout, e_ld); end
  endtask

  task automatic test_back_to_back;
    int ia, la, sa;
    logic ie, le, se;
    for (int n = 0; n < 80; n++) begin
      ie = 1'($urandom_range(0, 1)); le = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1));
      ia = $urandom_range(0, 19); la = $urandom_range(0, 19); sa = $urandom_range(0, 19);
      if (n % 7 == 0) la = sa;
      if (n % 11 == 0) ia = 4095;
      step(ie, ia, le, la, se, sa, 16'($urandom));
      e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
      vectors++; if ({if_valid, ld_valid} !== {exp_ifv, exp_ldv}) begin miscompares++; $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, {if_valid, ld_valid}, {exp_ifv, exp_ldv}); end
      vectors++; if (if_dout !== e_if) begin miscompares++; $display("FAIL b2b_if_dout n=%0d got=%h exp=%h", n, if_dout, e_if); end
      vectors++; if (ld_dout !== e_ld) begin miscompares++; $display("FAIL b2b_ld_dout n=%0d got=%h exp=%h", n, ld_dout, e_ld); end
    end
  endtask

  task automatic test_mid_clear_reset;
    rst_n = 1'b0; run = 1'b0; hold_if = '0; hold_ld = '0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 0, 1'b0, 0, 1'b0, 0, '0);
      e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
    end
    rst_n = 1'b0;
    #1;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready got=%b exp=0", ready); end
    #3 rst_n = 1'b1;
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 0, 1'b0, 0, 1'b1, 2, 16'h7777);
      e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
      vectors++; if (ready !== (i == D)) begin miscompares++; $display("FAIL mid_clear_ready cyc=%0d got=%b exp=%b", i, ready, (i == D)); end
    end
    for (int a = 0; a < D; a++) model[a] = '0;
    run = 1'b1;
    for (int a = 0; a < D; a++) begin
      step(1'b1, D - 1 - a, 1'b1, a, 1'b0, 0, '0);
      e_if = if_q.pop_front(); e_ld = ld_q.pop_front();
      vectors++; if (if_dout !== e_if) begin miscompares++; $display("FAIL mid_if_zero a=%0d got=%h exp=%h", D - 1 - a, if_dout, e_if); end
      vectors++; if (ld_dout !== e_ld) begin miscompares++; $display("FAIL mid_ld_zero a=%0d got=%h exp=%h", a, ld_dout, e_ld); end
    end
  endtask

  task automatic test_out_of_range;
    int n;
    rst2_n = 1'b1;
    n = 0;
    while (ready2 !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    vectors++; if (n != 64) begin miscompares++; $display("FAIL oor_clear_len got=%0d exp=64", n); end
    st2_en = 1; st2_addr = 8'd63; st2_din = 16'h5A5A;
    @(posedge clk); #1;
    st2_en = 1; st2_addr = 8'd200; st2_din = 16'hFFFF;
    ld2_en = 1; ld2_addr = 8'd63; ld2_q.push_back(16'h5A5A);
    @(posedge clk); #1;
    e2 = ld2_q.pop_front();
    vectors++; if (ld2_dout !== e2) begin miscompares++; $display("FAIL oor_ld63_a got=%h exp=%h", ld2_dout, e2); end
    st2_en = 1; st2_addr = 8'd200; st2_din = 16'hFFFF;
    ld2_en = 1; ld2_addr = 8'd200; ld2_q.push_back(16'h0000);
    if2_en = 1; if2_addr = 8'd200;
    @(posedge clk); #1;
    e2 = ld2_q.pop_front();
    vectors++; if (ld2_valid !== 1'b1) begin miscompares++; $display("FAIL oor_ld_valid got=%b exp=1", ld2_valid); end
    vectors++; if (ld2_dout !== e2) begin miscompares++; $display("FAIL oor_ld200 got=%h exp=%h", ld2_dout, e2); end
    vectors++; if ({if2_valid, if2_dout} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL oor_if200 got=%b/%h exp=1/0000", if2_valid, if2_dout); end
    if2_en = 0;
    st2_en = 1; st2_addr = 8'd64; st2_din = 16'h1111;
    ld2_en = 1; ld2_addr = 8'd63; ld2_q.push_back(16'h5A5A);
    @(posedge clk); #1;
    e2 = ld2_q.pop_front();
    vectors++; if (ld2_dout !== e2) begin miscompares++; $display("FAIL oor_ld63_b got=%h exp=%h", ld2_dout, e2); end
    st2_en = 0;
    ld2_en = 1; ld2_addr = 8'd64; ld2_q.push_back(16'h0000);
    @(posedge clk); #1;
    e2 = ld2_q.pop_front();
    vectors++; if ({ld2_valid, ld2_dout} !== {1'b1, e2}) begin miscompares++; $display("FAIL oor_ld64 got=%b/%h exp=1/%h", ld2_valid, ld2_dout, e2); end
    ld2_en = 1; ld2_addr = 8'd0; ld2_q.push_back(16'h0000);
    @(posedge clk); #1;
    e2 = ld2_q.pop_front();
    vectors++; if (ld2_dout !== e2) begin miscompares++; $display("FAIL oor_ld0_nowrap got=%h exp=%h", ld2_dout, e2); end
    ld2_en = 0;
  endtask

  initial begin
    test_reset();
    test_clear_lockout();
    test_clear_readback();
    test_fetch_load();
    test_write_first();
    test_back_to_back();
    test_mid_clear_reset();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
